// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg
//   Shared definitions for the multi-cycle control sequencer:
//   ALUOp encodings, FSM state type, opcode and funct field values.
package ctrl_sequencer_pkg;

  // ALU operation codes (4 bits wide; the sequencer casts to ALUW)
  localparam logic [3:0] kADD   = 4'd0;
  localparam logic [3:0] kSUB   = 4'd1;
  localparam logic [3:0] kNOT   = 4'd2;
  localparam logic [3:0] kBXOR  = 4'd3;
  localparam logic [3:0] kPASS  = 4'd4;
  localparam logic [3:0] kMOV   = 4'd5;
  localparam logic [3:0] kAND   = 4'd6;
  localparam logic [3:0] kSHIFT = 4'd7;
  localparam logic [3:0] kRXOR  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_MEM    = 2'd3
  } state_t;

  // Opcode values, compared against a zero-extended opcode so that
  // opcodes >= 8 (wider OPW) fall through to the illegal default.
  localparam int OP_MISC  = 0;
  localparam int OP_EQ    = 1;
  localparam int OP_ARITH = 2;
  localparam int OP_JAL   = 3;
  localparam int OP_MOV   = 4;
  localparam int OP_AND   = 5;
  localparam int OP_SH    = 6;
  localparam int OP_RXOR  = 7;

  // funct values for opcode 000
  localparam logic [1:0] F_LOAD  = 2'b00;
  localparam logic [1:0] F_STORE = 2'b01;
  localparam logic [1:0] F_NOT   = 2'b10;
  localparam logic [1:0] F_BXOR  = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
//   Purely combinational instruction decoder.
//   ir          : instruction word (opcode = ir[IW-1 -: OPW], funct = ir[1:0])
//   branch, jump, alusrc, reg_size, func_ex, aluop : static datapath controls
//   is_mem, is_load, writes_reg, illegal           : instruction class bits
module ctrl_decode
  import ctrl_sequencer_pkg::*;
#(
  parameter int IW   = 9,
  parameter int OPW  = 3,
  parameter int ALUW = 4
) (
  input  logic [IW-1:0]   ir,
  output logic            branch,
  output logic            jump,
  output logic            alusrc,
  output logic            reg_size,
  output logic            func_ex,
  output logic [ALUW-1:0] aluop,
  output logic            is_mem,
  output logic            is_load,
  output logic            writes_reg,
  output logic            illegal
);

  logic [OPW-1:0] op;
  logic [31:0]    op_ext;
  logic [1:0]     funct;
  // Register/operand fields are consumed by the datapath, not here.
  logic           unused_fields;

  assign op            = ir[IW-1 -: OPW];
  assign op_ext        = 32'(op);
  assign funct         = ir[1:0];
  assign unused_fields = ^ir[IW-OPW-1:2];

  always_comb begin
    branch     = 1'b0;
    jump       = 1'b0;
    alusrc     = 1'b1;
    reg_size   = 1'b1;
    func_ex    = 1'b0;
    aluop      = ALUW'(kPASS);
    is_mem     = 1'b0;
    is_load    = 1'b0;
    writes_reg = 1'b1;
    illegal    = 1'b0;
    case (op_ext)
      OP_MISC: begin
        case (funct)
          F_LOAD: begin
            aluop   = ALUW'(kADD);
            alusrc  = 1'b0;
            func_ex = 1'b1;
            is_mem  = 1'b1;
            is_load = 1'b1;
          end
          F_STORE: begin
            aluop      = ALUW'(kADD);
            alusrc     = 1'b0;
            func_ex    = 1'b1;
            is_mem     = 1'b1;
            writes_reg = 1'b0;
          end
          F_NOT: aluop = ALUW'(kNOT);
          default: begin
            aluop    = ALUW'(kBXOR);
            reg_size = 1'b0;
          end
        endcase
      end
      OP_EQ: begin
        aluop      = ALUW'(kSUB);
        branch     = 1'b1;
        writes_reg = 1'b0;
      end
      OP_ARITH: begin
        // funct[1] selects SUB over ADD, funct[0] selects the immediate form
        reg_size = 1'b0;
        aluop    = funct[1] ? ALUW'(kSUB) : ALUW'(kADD);
        alusrc   = ~funct[0];
      end
      OP_JAL: jump = 1'b1;
      OP_MOV: aluop = ALUW'(kMOV);
      OP_AND: aluop = ALUW'(kAND);
      OP_SH: begin
        aluop  = ALUW'(kSHIFT);
        alusrc = 1'b0;
      end
      OP_RXOR: aluop = ALUW'(kRXOR);
      default: begin
        // Unknown opcode executes as a NOP that flags itself
        illegal    = 1'b1;
        writes_reg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Multi-cycle control sequencer: accepts one instruction per handshake,
//   decodes it, then runs a one-cycle EXEC or a MEM_LAT-cycle MEM phase.
//   Clk, Reset (async, active-high)
//   instr/instr_valid/instr_ready : fetch handshake
//   zero                          : ALU zero flag, used in EXEC
//   Branch, Jump, ALUSrc, ALUOp, Reg_Size, Func_Ex : static controls
//   MemRead, MemWrite, RegWrite, pc_en, branch_taken, illegal : strobes
//   dbg_state                     : current FSM state
//   MEM_LAT must be 1..15 and 2**CNTW must exceed MEM_LAT.
//
// Handshake: an instruction transfers on a rising Clk edge where
// instr_valid and instr_ready are both 1. instr_ready is 1 only in IDLE;
// instr_valid while not ready is ignored and instr is not sampled.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int ALUW    = 4,
  parameter int MEM_LAT = 2,
  parameter int CNTW    = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [IW-1:0]   instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            zero,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Reg_Size,
  output logic            Func_Ex,
  output logic            Jump,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic [ALUW-1:0] ALUOp,
  output logic            pc_en,
  output logic            branch_taken,
  output logic            illegal,
  output state_t          dbg_state
);

  state_t          state_q, state_d;
  logic [IW-1:0]   ir_q;
  logic [CNTW-1:0] cnt_q;
  logic            branch_q, jump_q, alusrc_q, reg_size_q, func_ex_q;
  logic [ALUW-1:0] aluop_q;

  logic            accept;
  logic [IW-1:0]   dec_word;
  logic            dec_branch, dec_jump, dec_alusrc, dec_reg_size, dec_func_ex;
  logic [ALUW-1:0] dec_aluop;
  logic            dec_is_mem, dec_is_load, dec_writes_reg, dec_illegal;

  assign accept = (state_q == S_IDLE) && instr_valid;

  // In IDLE the decoder looks at the incoming word so the static controls
  // can be loaded together with IR and are already valid during DECODE.
  // After that it decodes IR, which holds steady until the next accept.
  assign dec_word = (state_q == S_IDLE) ? instr : ir_q;

  ctrl_decode #(
    .IW   (IW),
    .OPW  (OPW),
    .ALUW (ALUW)
  ) u_decode (
    .ir         (dec_word),
    .branch     (dec_branch),
    .jump       (dec_jump),
    .alusrc     (dec_alusrc),
    .reg_size   (dec_reg_size),
    .func_ex    (dec_func_ex),
    .aluop      (dec_aluop),
    .is_mem     (dec_is_mem),
    .is_load    (dec_is_load),
    .writes_reg (dec_writes_reg),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      cnt_q      <= '0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
      alusrc_q   <= 1'b1;
      reg_size_q <= 1'b1;
      func_ex_q  <= 1'b0;
      aluop_q    <= ALUW'(kPASS);
    end else begin
      state_q <= state_d;
      if (accept) begin
        ir_q       <= instr;
        branch_q   <= dec_branch;
        jump_q     <= dec_jump;
        alusrc_q   <= dec_alusrc;
        reg_size_q <= dec_reg_size;
        func_ex_q  <= dec_func_ex;
        aluop_q    <= dec_aluop;
      end
      if (state_q == S_DECODE && dec_is_mem)
        cnt_q <= CNTW'(MEM_LAT - 1);
      else if (state_q == S_MEM && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // Strobes are decoded from registered state only, so Reset clears them
  // immediately and an interrupted instruction leaves nothing behind.
  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    pc_en        = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = dec_is_mem ? S_MEM : S_EXEC;
      S_EXEC: begin
        pc_en        = 1'b1;
        RegWrite     = dec_writes_reg;
        branch_taken = branch_q & zero;
        illegal      = dec_illegal;
        state_d      = S_IDLE;
      end
      S_MEM: begin
        MemRead  = dec_is_load;
        // Counter starts at MEM_LAT-1, so that value marks the first MEM cycle
        MemWrite = ~dec_is_load && (cnt_q == CNTW'(MEM_LAT - 1));
        if (cnt_q == '0) begin
          pc_en    = 1'b1;
          RegWrite = dec_writes_reg;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Branch    = branch_q;
  assign Jump      = jump_q;
  assign ALUSrc    = alusrc_q;
  assign Reg_Size  = reg_size_q;
  assign Func_Ex   = func_ex_q;
  assign ALUOp     = aluop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer
//   Two sequencers share all inputs: dut_a with MEM_LAT = 2, dut_b with
//   MEM_LAT = 3. ALU-class vectors are table driven against dut_a; memory,
//   reset and back-to-back cases are hand-written sequences.
module tb_ctrl_sequencer;

  logic       Clk;
  logic       Reset;
  logic [8:0] instr;
  logic       instr_valid;
  logic       zero;

  logic       a_ready, a_branch, a_memread, a_memwrite, a_reg_size, a_func_ex;
  logic       a_jump, a_alusrc, a_regwrite, a_pc_en, a_btaken, a_illegal;
  logic [3:0] a_aluop;
  logic [1:0] a_state;
  logic       b_ready, b_branch, b_memread, b_memwrite, b_reg_size, b_func_ex;
  logic       b_jump, b_alusrc, b_regwrite, b_pc_en, b_btaken, b_illegal;
  logic [3:0] b_aluop;
  logic [1:0] b_state;

  int checks   = 0;
  int failures = 0;

  ctrl_sequencer #(.IW(9), .OPW(3), .ALUW(4), .MEM_LAT(2), .CNTW(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(a_ready), .zero(zero), .Branch(a_branch), .MemRead(a_memread),
    .MemWrite(a_memwrite), .Reg_Size(a_reg_size), .Func_Ex(a_func_ex),
    .Jump(a_jump), .ALUSrc(a_alusrc), .RegWrite(a_regwrite), .ALUOp(a_aluop),
    .pc_en(a_pc_en), .branch_taken(a_btaken), .illegal(a_illegal),
    .dbg_state(a_state)
  );

  ctrl_sequencer #(.IW(9), .OPW(3), .ALUW(4), .MEM_LAT(3), .CNTW(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(b_ready), .zero(zero), .Branch(b_branch), .MemRead(b_memread),
    .MemWrite(b_memwrite), .Reg_Size(b_reg_size), .Func_Ex(b_func_ex),
    .Jump(b_jump), .ALUSrc(b_alusrc), .RegWrite(b_regwrite), .ALUOp(b_aluop),
    .pc_en(b_pc_en), .branch_taken(b_btaken), .illegal(b_illegal),
    .dbg_state(b_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_both_idle();
    int n = 0;
    while (!(a_ready && b_ready) && n < 20) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, a_ready && b_ready}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [8:0] instr;
    logic       zero;
    logic [3:0] aluop;
    logic       reg_size;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       func_ex;
    logic       regwrite;
    logic       btaken;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    instr       = v.instr;
    zero        = v.zero;
    instr_valid = 1'b1;
    chk($sformatf("v%0d_ready", i), {31'd0, a_ready}, 32'd1);
    step();
    instr_valid = 1'b0;
    instr       = 9'h1FF;
    // DECODE: static controls visible, no strobes
    chk($sformatf("v%0d_dec_state", i), {30'd0, a_state}, 32'd1);
    chk($sformatf("v%0d_dec_ctrl", i),
        {23'd0, a_aluop, a_reg_size, a_alusrc, a_branch, a_jump, a_func_ex},
        {23'd0, v.aluop, v.reg_size, v.alusrc, v.branch, v.jump, v.func_ex});
    chk($sformatf("v%0d_dec_strobes", i),
        {26'd0, a_regwrite, a_pc_en, a_btaken, a_memread, a_memwrite, a_illegal}, 32'd0);
    step();
    // EXEC: commit
    chk($sformatf("v%0d_exec_state", i), {30'd0, a_state}, 32'd2);
    chk($sformatf("v%0d_exec_strobes", i),
        {26'd0, a_regwrite, a_pc_en, a_btaken, a_memread, a_memwrite, a_illegal},
        {26'd0, v.regwrite, 1'b1, v.btaken, 3'b000});
    step();
    chk($sformatf("v%0d_ready_again", i), {31'd0, a_ready}, 32'd1);
    chk($sformatf("v%0d_idle_strobes", i), {30'd0, a_regwrite, a_pc_en}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int pc_cnt;
    //         instr          z   aluop rs src br j  fe rw bt
    vecs[0]  = '{9'b000000010, 0, 4'd2, 1, 1, 0, 0, 0, 1, 0};  // NOT
    vecs[1]  = '{9'b000000011, 0, 4'd3, 0, 1, 0, 0, 0, 1, 0};  // BXOR
    vecs[2]  = '{9'b001000000, 1, 4'd1, 1, 1, 1, 0, 0, 0, 1};  // EQ, zero=1
    vecs[3]  = '{9'b001000000, 0, 4'd1, 1, 1, 1, 0, 0, 0, 0};  // EQ, zero=0
    vecs[4]  = '{9'b010000100, 0, 4'd0, 0, 1, 0, 0, 0, 1, 0};  // ADD
    vecs[5]  = '{9'b010000101, 0, 4'd0, 0, 0, 0, 0, 0, 1, 0};  // ADDI
    vecs[6]  = '{9'b010000110, 1, 4'd1, 0, 1, 0, 0, 0, 1, 0};  // SUB
    vecs[7]  = '{9'b010000111, 0, 4'd1, 0, 0, 0, 0, 0, 1, 0};  // SUBI
    vecs[8]  = '{9'b011000000, 1, 4'd4, 1, 1, 0, 1, 0, 1, 0};  // JAL
    vecs[9]  = '{9'b100000000, 0, 4'd5, 1, 1, 0, 0, 0, 1, 0};  // MOV
    vecs[10] = '{9'b101000000, 0, 4'd6, 1, 1, 0, 0, 0, 1, 0};  // AND
    vecs[11] = '{9'b110000000, 0, 4'd7, 1, 0, 0, 0, 0, 1, 0};  // SH
    vecs[12] = '{9'b111000000, 0, 4'd8, 1, 1, 0, 0, 0, 1, 0};  // RXOR
    vecs[13] = '{9'b001000001, 1, 4'd1, 1, 1, 1, 0, 0, 0, 1};  // EQ, funct ignored

    Reset       = 1'b1;
    instr       = 9'd0;
    instr_valid = 1'b0;
    zero        = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    // Reset state
    chk("rst_state", {30'd0, a_state}, 32'd0);
    chk("rst_ctrl",
        {23'd0, a_aluop, a_reg_size, a_alusrc, a_branch, a_jump, a_func_ex},
        {23'd0, 4'd4, 1'b1, 1'b1, 3'b000});
    chk("rst_strobes",
        {26'd0, a_regwrite, a_pc_en, a_btaken, a_memread, a_memwrite, a_illegal}, 32'd0);
    Reset = 1'b0;
    step();
    chk("rst_ready", {31'd0, a_ready}, 32'd1);

    // Table-driven ALU/branch/jump instructions
    for (int i = 0; i < 14; i++) run_vec(i);

    // LOAD on dut_a (MEM_LAT = 2): MemRead cycles 2-3, commit at cycle 3
    instr       = 9'b000000000;
    instr_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      instr_valid = 1'b0;
      if (c == 1)
        chk("load_dec_ctrl", {30'd0, a_func_ex, a_alusrc}, {30'd0, 1'b1, 1'b0});
      chk($sformatf("load_c%0d_memread", c), {31'd0, a_memread}, {31'd0, c >= 2});
      chk($sformatf("load_c%0d_commit", c), {30'd0, a_regwrite, a_pc_en},
          {30'd0, c == 3, c == 3});
      chk($sformatf("load_c%0d_memwrite", c), {31'd0, a_memwrite}, 32'd0);
    end
    step();
    chk("load_ready_again", {31'd0, a_ready}, 32'd1);
    wait_both_idle();

    // STORE on dut_b (MEM_LAT = 3): MemWrite cycle 2 only, commit at cycle 4
    instr       = 9'b000000001;
    instr_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      instr_valid = 1'b0;
      chk($sformatf("store_c%0d_memwrite", c), {31'd0, b_memwrite}, {31'd0, c == 2});
      chk($sformatf("store_c%0d_rd_wr", c), {30'd0, b_memread, b_regwrite}, 32'd0);
      chk($sformatf("store_c%0d_pc_en", c), {31'd0, b_pc_en}, {31'd0, c == 4});
    end
    step();
    chk("store_ready_again", {31'd0, b_ready}, 32'd1);
    wait_both_idle();

    // Back-to-back: valid held high, ADDI then JAL on dut_a
    pc_cnt      = 0;
    instr       = 9'b010000001;
    instr_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) instr = 9'b011000000;
      if (a_pc_en) pc_cnt++;
      case (c)
        1: chk("b2b_c1", {30'd0, a_ready, a_alusrc}, 32'd0);
        2: chk("b2b_c2", {29'd0, a_jump, a_pc_en, a_regwrite}, {29'd0, 3'b011});
        3: chk("b2b_c3", {30'd0, a_ready, a_jump}, {30'd0, 2'b10});
        4: begin
          chk("b2b_c4", {25'd0, a_jump, a_aluop, a_state}, {25'd0, 1'b1, 4'd4, 2'd1});
          instr_valid = 1'b0;
        end
        5: chk("b2b_c5", {29'd0, a_jump, a_pc_en, a_regwrite}, {29'd0, 3'b111});
        6: chk("b2b_c6", {31'd0, a_ready}, 32'd1);
        default: chk("b2b_c7_idle", {30'd0, a_state}, 32'd0);
      endcase
    end
    chk("b2b_pc_count", pc_cnt, 32'd2);

    // Reset during the first MEM cycle of a STORE
    instr       = 9'b000000001;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("rst_mid_pre_memwrite", {31'd0, b_memwrite}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rst_mid_strobes",
        {26'd0, a_memwrite, a_regwrite, a_pc_en, b_memwrite, b_regwrite, b_pc_en}, 32'd0);
    chk("rst_mid_state", {28'd0, a_state, b_state}, 32'd0);
    chk("rst_mid_aluop", {28'd0, b_aluop}, 32'd4);
    step();
    Reset = 1'b0;
    step();
    chk("rst_mid_ready", {30'd0, a_ready, b_ready}, {30'd0, 2'b11});
    chk("rst_mid_no_commit", {30'd0, b_pc_en, b_memwrite}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control sequencer for the 9-bit hamming/parity core. Generalised successor to the single-cycle control decoder.
- Accepts one instruction per valid/ready handshake and latches it into an instruction register. Decodes it, then sequences the execute or memory phase over a parametrised number of cycles.
- Emits registered datapath controls, plus pc_en and branch_taken commit strobes.
- Sits between instruction fetch and the datapath (regfile, ALU, data memory).

Parameters:
IW, 9, instruction width
OPW, 3, opcode width; opcode = instr[IW-1 -: OPW]; funct = instr[1:0]
ALUW, 4, ALUOp width
MEM_LAT, 2, data-memory access cycles (1..15)
CNTW, 4, memory-wait counter width; must satisfy 2**CNTW > MEM_LAT

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high
instr  in  IW  instruction word from fetch
instr_valid  in  1  instr is valid
instr_ready  out  1  sequencer can accept an instruction
zero  in  1  ALU zero flag, sampled in EXEC
Branch  out  1  current instruction is EQ
MemRead  out  1  data-memory read enable
MemWrite  out  1  data-memory write strobe
Reg_Size  out  1  0 = H-type operand size, 1 = C/M-type
Func_Ex  out  1  M-type extended function
Jump  out  1  JAL
ALUSrc  out  1  0 = immediate operand
RegWrite  out  1  regfile write strobe, commit cycle only
ALUOp  out  ALUW  ALU operation code
pc_en  out  1  one-cycle PC advance strobe
branch_taken  out  1  Branch & zero, commit cycle only
illegal  out  1  one-cycle pulse when opcode >= 8 (only possible with OPW > 3)

Behaviour:
- States: IDLE, DECODE, EXEC, MEM.
- Reset (async, any state): state = IDLE, IR = 0, counter = 0.
  - All strobes 0: RegWrite, MemRead, MemWrite, pc_en, branch_taken, illegal.
  - Static controls at decoder defaults: ALUOp = kPASS, Reg_Size = 1, ALUSrc = 1, Branch/Jump/Func_Ex = 0.
  - An in-flight instruction is discarded; no partial write may reach memory or the regfile.
- IDLE: instr_ready = 1. On instr_valid, IR <= instr and go to DECODE. instr_ready is 0 in every other state.
- DECODE, one cycle:
  - The decoder output is registered onto the static controls (Branch, Jump, ALUSrc, ALUOp, Reg_Size, Func_Ex). These hold until the next DECODE.
  - LOAD or STORE: counter <= MEM_LAT-1, go to MEM.
  - Otherwise: go to EXEC.
- Decode map, opcode/funct:
  - 000/00 LOAD: kADD, ALUSrc = 0, Func_Ex = 1, MemRead, RegWrite.
  - 000/01 STORE: kADD, ALUSrc = 0, Func_Ex = 1, MemWrite, no RegWrite.
  - 000/10 NOT: kNOT.
  - 000/11 BXOR: kBXOR, Reg_Size = 0.
  - 001 EQ: kSUB, Branch, no RegWrite.
  - 010, all with Reg_Size = 0: funct 00 ADD kADD; 01 ADDI kADD with ALUSrc = 0; 10 SUB kSUB; 11 SUBI kSUB with ALUSrc = 0.
  - 011 JAL: kPASS, Jump.
  - 100 MOV: kMOV.
  - 101 AND: kAND.
  - 110 SH: kSHIFT, ALUSrc = 0.
  - 111 RXOR: kRXOR.
  - opcode >= 8: treated as NOP; illegal pulses in EXEC and no RegWrite.
- EXEC, one cycle, commit:
  - pc_en = 1.
  - RegWrite = 1 unless EQ, STORE or illegal.
  - branch_taken = Branch & zero.
  - Next state: IDLE.
- MEM:
  - MemRead held high in every MEM cycle of a LOAD.
  - MemWrite high only in the first MEM cycle of a STORE.
  - Counter decrements each cycle. When it reaches 0: commit (pc_en = 1; RegWrite = 1 for LOAD) and go to IDLE.
  - Total MEM cycles = MEM_LAT.
- Latency:
  - ALU/branch/jump instruction: handshake at cycle 0, commit at cycle 2, ready again at cycle 3.
  - LOAD/STORE: commit at cycle 1+MEM_LAT.
- instr_valid while not ready is ignored; instr is not sampled.
- Strobes never assert in IDLE or DECODE.

Decomposition:
- Package definitions: ALUOp constants (kADD, kSUB, kNOT, kBXOR, kPASS, kMOV, kAND, kSHIFT, kRXOR), state enum typedef, opcode/funct localparams.
- Sub-module ctrl_decode: purely combinational IR -> static controls plus class bits (is_mem, is_load, writes_reg, illegal). The sequencer owns IR, FSM, counter and registers.

Test Plan:
- Reset: Reset high mid-MEM of a STORE -> MemWrite, RegWrite, pc_en are 0 immediately; state IDLE; instr_ready = 1 after release; ALUOp = kPASS.
- ADD 9'b010000100, valid at cycle 0 -> DECODE at cycle 1 with ALUOp = kADD, Reg_Size = 0, ALUSrc = 1; cycle 2 RegWrite = 1, pc_en = 1; instr_ready = 1 at cycle 3.
- LOAD 9'b000000000 with MEM_LAT = 2 -> MemRead high in cycles 2–3, RegWrite and pc_en only in cycle 3, Func_Ex = 1, ALUSrc = 0.
- STORE 9'b000000001 with MEM_LAT = 3 -> MemWrite high in cycle 2 only, MemRead 0, RegWrite never, pc_en in cycle 4.
- EQ 9'b001000000: zero = 1 -> branch_taken = 1 and RegWrite = 0 in EXEC; repeat with zero = 0 -> branch_taken = 0.
- Back-to-back valid held high with ADDI then JAL -> second instruction accepted only when instr_ready = 1 (cycle 3); Jump = 1 from cycle 4; no instruction dropped or duplicated.
